// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 data multiplexer; select code matches the SEL_* constants.
module mux4_sel
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] y
);

    // Route the selected requester's data to the output.
    always_comb begin
        y = a;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            SEL_C:   y = c;
            SEL_D:   y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux, with capped tenure and registered data out.
//
// state | meaning
// IDLE  | no owner; grant=0, selects hold last value, search starts at ptr
// GRANT | owner = sel_q; hold_cnt counts tenure, release on req drop or cap
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        grant,
    output logic              s1,
    output logic              s2,
    output logic              busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
);

    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;

    logic [1:0]         scan_start;
    logic [1:0]         pick_idx;
    logic               pick_found;
    logic [1:0]         cand;
    logic [DATA_W-1:0]  mux_out;

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_sel (
        .sel (sel_q),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .y   (mux_out)
    );

    // Idle searches from ptr; a releasing owner searches from the next index and sees itself last.
    always_comb begin
        scan_start = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;
    end

    // Rotate-priority encode: first set request at or after scan_start, wrapping mod 4.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = scan_start;
        cand       = scan_start;
        for (int i = 0; i < 4; i++) begin
            cand = scan_start + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Arbitration FSM: grant, release and back-to-back re-arbitration.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    grant_d    = idx_to_onehot(pick_idx);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (hold_cnt_q == HOLD_LAST)) begin
                    ptr_d      = sel_q + 2'd1;
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = idx_to_onehot(pick_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // Data capture: follow the selected input while busy, otherwise hold the last value.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = busy;
        if (busy) begin
            dout_d = mux_out;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 4'b0000;
            sel_q        <= SEL_A;
            ptr_q        <= 2'd0;
            hold_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign busy       = (state_q == GRANT);
    assign grant      = grant_q;
    assign s1         = sel_q[1];
    assign s2         = sel_q[0];
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with HOLD_MAX=8, one with HOLD_MAX=2.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a, b, c, d;

    logic [3:0] g8, g2;
    logic       s1_8, s2_8, s1_2, s2_2;
    logic       busy8, busy2;
    logic [3:0] dout8, dout2;
    logic       dv8, dv2;

    int errors = 0;
    int checks = 0;

    mux4_rr_arbiter #(.DATA_W(4), .HOLD_MAX(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .grant(g8), .s1(s1_8), .s2(s2_8), .busy(busy8), .dout(dout8), .dout_valid(dv8)
    );

    mux4_rr_arbiter #(.DATA_W(4), .HOLD_MAX(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .grant(g2), .s1(s1_2), .s2(s2_2), .busy(busy2), .dout(dout2), .dout_valid(dv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_fair [10];
    logic [3:0] data_tab [4];

    initial begin
        exp_fair = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                     4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        a = 4'hA; b = 4'hB; c = 4'hC; d = 4'hD;
        data_tab = '{4'hA, 4'hB, 4'hC, 4'hD};
        rst_n = 1'b1;
        req   = 4'h0;

        // 1: reset held with all requests pending
        #1;
        rst_n = 1'b0;
        req   = 4'hF;
        #1;
        check("rst_grant", g8, 4'b0000);
        check("rst_sel", {s1_8, s2_8}, 2'b00);
        check("rst_busy", busy8, 1'b0);
        check("rst_dv", dv8, 1'b0);
        check("rst_dout", dout8, 4'h0);
        tick();
        tick();
        check("rst_hold_grant", g8, 4'b0000);
        check("rst_hold_dv", dv8, 1'b0);
        rst_n = 1'b1;
        tick();
        check("first_grant", g8, 4'b0001);
        check("first_busy", busy8, 1'b1);
        check("first_dv_lag", dv8, 1'b0);
        tick();
        check("first_dout", dout8, 4'hA);
        check("first_dv", dv8, 1'b1);

        // 2: single request from c, then drop
        req = 4'b0100;
        pulse_reset();
        tick();
        check("single_grant", g8, 4'b0100);
        check("single_sel", {s1_8, s2_8}, 2'b10);
        check("single_dv0", dv8, 1'b0);
        tick();
        check("single_dout", dout8, 4'hC);
        check("single_dv1", dv8, 1'b1);
        req = 4'b0000;
        tick();
        check("drop_grant", g8, 4'b0000);
        check("drop_busy", busy8, 1'b0);
        check("drop_dv_lag", dv8, 1'b1);
        tick();
        check("drop_dv", dv8, 1'b0);
        check("drop_dout_hold", dout8, 4'hC);
        check("drop_sel_hold", {s1_8, s2_8}, 2'b10);

        // 3: fairness with HOLD_MAX=2, all requesting
        req = 4'hF;
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("fair_grant_%0d", k), g2, exp_fair[k]);
            check($sformatf("fair_busy_%0d", k), busy2, 1'b1);
            if (k > 0) begin
                check($sformatf("fair_dout_%0d", k), dout2, data_tab[(k - 1) / 2 % 4]);
            end
        end

        // 4: early release by b, next search starts at c
        req = 4'b0010;
        pulse_reset();
        tick();
        check("early_b1", g8, 4'b0010);
        tick();
        check("early_b2", g8, 4'b0010);
        tick();
        check("early_b3", g8, 4'b0010);
        req = 4'b1001;
        tick();
        check("early_next_d", g8, 4'b1000);
        check("early_sel_d", {s1_8, s2_8}, 2'b11);
        tick();
        check("early_d_hold", g8, 4'b1000);
        req = 4'b0001;
        tick();
        check("early_then_a", g8, 4'b0001);

        // 5: lone hog on HOLD_MAX=8; cap re-grant at tick 9 restarts the tenure count
        req = 4'b0001;
        pulse_reset();
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("hog_grant_%0d", k), g8, 4'b0001);
            check($sformatf("hog_busy_%0d", k), busy8, 1'b1);
        end
        req = 4'b0011;
        for (int k = 13; k <= 16; k++) begin
            tick();
            check($sformatf("hog_keep_%0d", k), g8, 4'b0001);
        end
        tick();
        check("hog_to_b", g8, 4'b0010);
        check("hog_b_busy", busy8, 1'b1);

        // 6: asynchronous reset in the middle of c's tenure
        req = 4'b0100;
        pulse_reset();
        tick();
        tick();
        check("mid_pre_grant", g8, 4'b0100);
        check("mid_pre_dv", dv8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_grant", g8, 4'b0000);
        check("mid_sel", {s1_8, s2_8}, 2'b00);
        check("mid_busy", busy8, 1'b0);
        check("mid_dout", dout8, 4'h0);
        check("mid_dv", dv8, 1'b0);
        req = 4'hF;
        #1;
        rst_n = 1'b1;
        tick();
        check("mid_after_grant", g8, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
